// File: rtl/fwd_lookup_ctrl.sv
// fwd_lookup_ctrl: per-frame forwarding decision engine between the
// header parser and the MAC table (learn + lookup, then descriptor).
// Ports: hdr_* header in (valid/ready), learn_* / read_* table requests,
// read_port_i/read_port_valid_i table result, fwd_* descriptor out.
// Optional FWD_LOOKUP_STATS_EN adds stat_ucast_o/stat_flood_o/stat_drop_o.
module fwd_lookup_ctrl #(
  parameter int NUM_PORTS  = 4,
  parameter int LOOKUP_LAT = 1,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hdr_valid_i,
  output logic                 hdr_ready_o,
  input  logic [47:0]          hdr_dst_i,
  input  logic [47:0]          hdr_src_i,
  input  logic [PW-1:0]        hdr_port_i,
  output logic                 learn_req_o,
  output logic [47:0]          learn_address_o,
  output logic [PW-1:0]        learn_port_o,
  output logic                 read_req_o,
  output logic [47:0]          read_address_o,
  input  logic [PW-1:0]        read_port_i,
  input  logic                 read_port_valid_i,
  output logic                 fwd_valid_o,
  input  logic                 fwd_ready_i,
  output logic [NUM_PORTS-1:0] fwd_mask_o,
  output logic                 fwd_flood_o,
  output logic                 fwd_drop_o
`ifdef FWD_LOOKUP_STATS_EN
  ,
  output logic [31:0]          stat_ucast_o,
  output logic [31:0]          stat_flood_o,
  output logic [31:0]          stat_drop_o
`endif
);

  localparam int CW  = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam int PW1 = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q;
  logic                 hdr_ready_q;
  logic [47:0]          dst_q;
  logic [47:0]          src_q;
  logic [PW-1:0]        port_q;
  logic                 learn_req_q;
  logic                 read_req_q;
  logic [CW-1:0]        cnt_q;
  logic                 fwd_valid_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic                 flood_q;
  logic                 drop_q;

  logic [NUM_PORTS-1:0] mask_d;
  logic                 flood_d;
  logic                 drop_d;
  logic                 in_range;
  logic                 hit;

  // Out-of-range result ports fall back to flooding; group
  // destinations never use the table result.
  always_comb begin
    in_range = {1'b0, read_port_i} < PW1'(NUM_PORTS);
    hit      = read_port_valid_i && in_range && !dst_q[40];
    mask_d   = ~(NUM_PORTS'(1) << port_q);
    flood_d  = 1'b1;
    drop_d   = 1'b0;
    if (hit) begin
      flood_d = 1'b0;
      if (read_port_i == port_q) begin
        mask_d = '0;
        drop_d = 1'b1;
      end else begin
        mask_d = NUM_PORTS'(1) << read_port_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hdr_ready_q <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      port_q      <= '0;
      learn_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      cnt_q       <= '0;
      fwd_valid_q <= 1'b0;
      mask_q      <= '0;
      flood_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      learn_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hdr_valid_i && hdr_ready_q) begin
            dst_q       <= hdr_dst_i;
            src_q       <= hdr_src_i;
            port_q      <= hdr_port_i;
            // Requests fire in the REQ cycle; group source never learned.
            learn_req_q <= ~hdr_src_i[40];
            read_req_q  <= ~hdr_dst_i[40];
            hdr_ready_q <= 1'b0;
            state_q     <= S_REQ;
          end else begin
            hdr_ready_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (!dst_q[40]) begin
            cnt_q   <= CW'(LOOKUP_LAT - 1);
            state_q <= S_WAIT;
          end else begin
            fwd_valid_q <= 1'b1;
            mask_q      <= mask_d;
            flood_q     <= flood_d;
            drop_q      <= drop_d;
            state_q     <= S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            fwd_valid_q <= 1'b1;
            mask_q      <= mask_d;
            flood_q     <= flood_d;
            drop_q      <= drop_d;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (fwd_ready_i) begin
            fwd_valid_q <= 1'b0;
            hdr_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hdr_ready_o     = hdr_ready_q;
  assign learn_req_o     = learn_req_q;
  assign learn_address_o = src_q;
  assign learn_port_o    = port_q;
  assign read_req_o      = read_req_q;
  assign read_address_o  = dst_q;
  assign fwd_valid_o     = fwd_valid_q;
  assign fwd_mask_o      = mask_q;
  assign fwd_flood_o     = flood_q;
  assign fwd_drop_o      = drop_q;

`ifdef FWD_LOOKUP_STATS_EN
  logic [31:0] st_uc_q;
  logic [31:0] st_fl_q;
  logic [31:0] st_dr_q;
  logic        hs;

  assign hs = fwd_valid_q && fwd_ready_i;

  // Saturating class counters, bumped on the descriptor handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_uc_q <= '0;
      st_fl_q <= '0;
      st_dr_q <= '0;
    end else if (hs) begin
      if (drop_q) begin
        if (st_dr_q != '1) st_dr_q <= st_dr_q + 1'b1;
      end else if (flood_q) begin
        if (st_fl_q != '1) st_fl_q <= st_fl_q + 1'b1;
      end else begin
        if (st_uc_q != '1) st_uc_q <= st_uc_q + 1'b1;
      end
    end
  end

  assign stat_ucast_o = st_uc_q;
  assign stat_flood_o = st_fl_q;
  assign stat_drop_o  = st_dr_q;
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_fwd_lookup_ctrl.sv
// tb_fwd_lookup_ctrl: directed bench for fwd_lookup_ctrl
// (LOOKUP_LAT=1 and LOOKUP_LAT=3 instances).
module tb_fwd_lookup_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hdr_valid, hdr_ready;
  logic [47:0] hdr_dst, hdr_src;
  logic [1:0]  hdr_port;
  logic        learn_req, read_req;
  logic [47:0] learn_addr, read_addr;
  logic [1:0]  learn_port, read_port;
  logic        read_pv;
  logic        fwd_valid, fwd_ready;
  logic [3:0]  fwd_mask;
  logic        fwd_flood, fwd_drop;

  logic        b_hdr_valid, b_hdr_ready;
  logic [47:0] b_hdr_dst, b_hdr_src;
  logic [1:0]  b_hdr_port;
  logic        b_learn_req, b_read_req;
  logic [47:0] b_learn_addr, b_read_addr;
  logic [1:0]  b_learn_port, b_read_port;
  logic        b_read_pv;
  logic        b_fwd_valid, b_fwd_ready;
  logic [3:0]  b_fwd_mask;
  logic        b_fwd_flood, b_fwd_drop;

`ifdef FWD_LOOKUP_STATS_EN
  logic [31:0] st_uc, st_fl, st_dr;
  logic [31:0] b_st_uc, b_st_fl, b_st_dr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int eu = 0, ef = 0, ed = 0;

  fwd_lookup_ctrl #(.NUM_PORTS(4), .LOOKUP_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid_i(hdr_valid), .hdr_ready_o(hdr_ready),
    .hdr_dst_i(hdr_dst), .hdr_src_i(hdr_src),
    .hdr_port_i(hdr_port),
    .learn_req_o(learn_req), .learn_address_o(learn_addr),
    .learn_port_o(learn_port),
    .read_req_o(read_req), .read_address_o(read_addr),
    .read_port_i(read_port), .read_port_valid_i(read_pv),
    .fwd_valid_o(fwd_valid), .fwd_ready_i(fwd_ready),
    .fwd_mask_o(fwd_mask), .fwd_flood_o(fwd_flood),
    .fwd_drop_o(fwd_drop)
`ifdef FWD_LOOKUP_STATS_EN
    ,
    .stat_ucast_o(st_uc), .stat_flood_o(st_fl),
    .stat_drop_o(st_dr)
`endif
  );

  fwd_lookup_ctrl #(.NUM_PORTS(4), .LOOKUP_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid_i(b_hdr_valid), .hdr_ready_o(b_hdr_ready),
    .hdr_dst_i(b_hdr_dst), .hdr_src_i(b_hdr_src),
    .hdr_port_i(b_hdr_port),
    .learn_req_o(b_learn_req), .learn_address_o(b_learn_addr),
    .learn_port_o(b_learn_port),
    .read_req_o(b_read_req), .read_address_o(b_read_addr),
    .read_port_i(b_read_port), .read_port_valid_i(b_read_pv),
    .fwd_valid_o(b_fwd_valid), .fwd_ready_i(b_fwd_ready),
    .fwd_mask_o(b_fwd_mask), .fwd_flood_o(b_fwd_flood),
    .fwd_drop_o(b_fwd_drop)
`ifdef FWD_LOOKUP_STATS_EN
    ,
    .stat_ucast_o(b_st_uc), .stat_flood_o(b_st_fl),
    .stat_drop_o(b_st_dr)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(
    input string       tag,
    input logic [47:0] dst,
    input logic [47:0] src,
    input logic [1:0]  port,
    input logic        hit,
    input logic [1:0]  rp,
    input logic [3:0]  e_mask,
    input logic        e_flood,
    input logic        e_drop,
    input logic        e_learn,
    input logic        e_read,
    input int          e_lat,
    input int          hold
  );
    int cyc;
    bit ok;
    check({tag, "_rdy"}, hdr_ready, 1);
    hdr_valid = 1'b1;
    hdr_dst   = dst;
    hdr_src   = src;
    hdr_port  = port;
    read_pv   = hit;
    read_port = rp;
    tick;
    hdr_valid = 1'b0;
    check({tag, "_learn"}, learn_req, e_learn);
    check({tag, "_read"}, read_req, e_read);
    check({tag, "_laddr"}, learn_addr, src);
    check({tag, "_raddr"}, read_addr, dst);
    check({tag, "_lport"}, learn_port, port);
    check({tag, "_busy"}, hdr_ready, 0);
    cyc = 1;
    while (!fwd_valid && cyc < 20) begin
      tick;
      cyc++;
      if (cyc == 2) check({tag, "_pulse"}, {learn_req, read_req}, 0);
    end
    check({tag, "_lat"}, cyc, e_lat);
    check({tag, "_mask"}, fwd_mask, e_mask);
    check({tag, "_flood"}, fwd_flood, e_flood);
    check({tag, "_drop"}, fwd_drop, e_drop);
    ok = 1'b1;
    repeat (hold) begin
      tick;
      if (!fwd_valid || hdr_ready || fwd_mask !== e_mask ||
          fwd_flood !== e_flood || fwd_drop !== e_drop)
        ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, ok, 1);
    fwd_ready = 1'b1;
    tick;
    fwd_ready = 1'b0;
    check({tag, "_vld_off"}, fwd_valid, 0);
    check({tag, "_rdy_back"}, hdr_ready, 1);
    if (e_drop) ed++;
    else if (e_flood) ef++;
    else eu++;
  endtask

  task automatic lat3_frame(input string tag, input logic samp,
                            input logic [3:0] e_mask,
                            input logic e_flood);
    int cyc;
    check({tag, "_rdy"}, b_hdr_ready, 1);
    b_hdr_valid = 1'b1;
    b_hdr_dst   = 48'h0011_2233_4455;
    b_hdr_src   = 48'h00AA_BBCC_DDEE;
    b_hdr_port  = 2'd0;
    b_read_port = 2'd1;
    b_read_pv   = ~samp;
    tick;
    b_hdr_valid = 1'b0;
    check({tag, "_read"}, b_read_req, 1);
    cyc = 1;
    while (!b_fwd_valid && cyc < 20) begin
      b_read_pv = (cyc == 4) ? samp : ~samp;
      tick;
      cyc++;
    end
    b_read_pv = ~samp;
    check({tag, "_lat"}, cyc, 5);
    check({tag, "_mask"}, b_fwd_mask, e_mask);
    check({tag, "_flood"}, b_fwd_flood, e_flood);
    b_fwd_ready = 1'b1;
    tick;
    b_fwd_ready = 1'b0;
    check({tag, "_vld_off"}, b_fwd_valid, 0);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    hdr_valid = 0; hdr_dst = '0; hdr_src = '0; hdr_port = '0;
    read_port = '0; read_pv = 0; fwd_ready = 0;
    b_hdr_valid = 0; b_hdr_dst = '0; b_hdr_src = '0;
    b_hdr_port = '0; b_read_port = '0; b_read_pv = 0;
    b_fwd_ready = 0;
    repeat (3) tick;
    check("rst_rdy", hdr_ready, 0);
    check("rst_vld", fwd_valid, 0);
    check("rst_reqs", {learn_req, read_req}, 0);
    check("rst_mask", fwd_mask, 0);
    check("rst_raddr", read_addr, 0);
    check("rst_b_rdy", b_hdr_ready, 0);
    rst_n = 1'b1;
    tick;
    check("post_rst_rdy", hdr_ready, 1);

    run_frame("uc_hit", 48'h0011_2233_4455, 48'h00AA_BBCC_DDEE,
              2'd2, 1, 2'd1, 4'b0010, 0, 0, 1, 1, 3, 0);
    run_frame("uc_miss", 48'h0011_2233_4455, 48'h00AA_BBCC_DDEE,
              2'd0, 0, 2'd1, 4'b1110, 1, 0, 1, 1, 3, 0);
    run_frame("bcast", 48'hFFFF_FFFF_FFFF, 48'h00AA_BBCC_DDEE,
              2'd3, 0, 2'd0, 4'b0111, 1, 0, 1, 0, 2, 0);
    run_frame("self", 48'h0011_2233_4455, 48'h00AA_BBCC_DDEE,
              2'd2, 1, 2'd2, 4'b0000, 0, 1, 1, 1, 3, 0);
    run_frame("grp_src", 48'h0011_2233_4466, 48'h0100_5E00_0001,
              2'd0, 1, 2'd3, 4'b1000, 0, 0, 0, 1, 3, 0);
    run_frame("bp", 48'h0011_2233_4477, 48'h00AA_BBCC_DD01,
              2'd1, 1, 2'd0, 4'b0001, 0, 0, 1, 1, 3, 10);
    run_frame("mcast", 48'h0100_5E00_00FB, 48'h00AA_BBCC_DD02,
              2'd1, 1, 2'd1, 4'b1101, 1, 0, 1, 0, 2, 0);

    lat3_frame("l3_miss", 1'b0, 4'b1110, 1'b1);
    lat3_frame("l3_hit", 1'b1, 4'b0010, 1'b0);

`ifdef FWD_LOOKUP_STATS_EN
    check("st_uc", st_uc, eu);
    check("st_fl", st_fl, ef);
    check("st_dr", st_dr, ed);
    check("b_st_uc", b_st_uc, 1);
    check("b_st_fl", b_st_fl, 1);
    check("b_st_dr", b_st_dr, 0);
`endif

    // Reset while the frame sits in WAIT.
    hdr_valid = 1'b1;
    hdr_dst   = 48'h0011_2233_4455;
    hdr_src   = 48'h00AA_BBCC_DDEE;
    hdr_port  = 2'd2;
    read_pv   = 1'b1;
    read_port = 2'd1;
    tick;
    hdr_valid = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rdy", hdr_ready, 0);
    check("arst_vld", fwd_valid, 0);
    check("arst_mask", fwd_mask, 0);
    check("arst_raddr", read_addr, 0);
    check("arst_laddr", learn_addr, 0);
    check("arst_reqs", {learn_req, read_req}, 0);
    eu = 0; ef = 0; ed = 0;
    rst_n = 1'b1;
    fwd_ready = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      tick;
      if (fwd_valid) ok = 1'b0;
    end
    fwd_ready = 1'b0;
    check("arst_no_desc", ok, 1);
    check("arst_rdy_back", hdr_ready, 1);
`ifdef FWD_LOOKUP_STATS_EN
    check("st_uc_rst", st_uc, eu);
    check("st_fl_rst", st_fl, ef);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
